// File: rtl/wimax_burst_sequencer.sv
// ---------------------------------------------------------------------------
// wimax_burst_sequencer
//  Frame-level controller in front of the WiMAX PHY chain
//  (PRBS -> FEC -> interleaver -> QPSK). For each burst it pulses the PRBS
//  seed load, then forwards BLOCK_BITS serial bits from the upstream source
//  into the randomizer and waits for the BLOCK_BITS/2 modulator symbols that
//  belong to them. Runs a programmed number of bursts (0 = until stop).
//  A watchdog moves to ERROR when the chain stops moving.
//
// Ports
//  i_clk_50, i_reset       clock, synchronous active-high reset
//  i_start, i_stop         run control pulses
//  i_num_frames            bursts per run (0 = continuous), latched on start
//  i_src_data/valid        upstream bit stream, o_src_ready back-pressure
//  o_phy_load/en           PRBS seed load pulse / chain enable
//  o_phy_data/valid        bit stream into the randomizer, i_phy_ready back
//  i_mod_valid/o_mod_ready modulator symbol handshake
//  o_busy, o_frame_done    status, per-burst completion pulse
//  o_frames_sent           bursts completed this run
//  o_timeout_err           sticky watchdog flag
// ---------------------------------------------------------------------------
module wimax_burst_sequencer #(
  parameter int BLOCK_BITS     = 96,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FRAME_W        = 8
) (
  input  logic               i_clk_50,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [FRAME_W-1:0] i_num_frames,
  input  logic               i_src_data,
  input  logic               i_src_valid,
  output logic               o_src_ready,
  output logic               o_phy_load,
  output logic               o_phy_en,
  output logic               o_phy_data,
  output logic               o_phy_valid,
  input  logic               i_phy_ready,
  input  logic               i_mod_valid,
  output logic               o_mod_ready,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [FRAME_W-1:0] o_frames_sent,
  output logic               o_timeout_err
);

  localparam int SYMS  = BLOCK_BITS / 2;
  localparam int IN_W  = $clog2(BLOCK_BITS + 1);
  localparam int SYM_W = $clog2(SYMS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t             r_state;
  logic [IN_W-1:0]    r_in_cnt;
  logic [SYM_W-1:0]   r_sym_cnt;
  logic [WD_W-1:0]    r_wd;
  logic [FRAME_W-1:0] r_num_frames;
  logic [FRAME_W-1:0] r_frames_sent;
  logic               r_stop_req;
  logic               r_timeout_err;

  logic w_stream, w_drain, w_active, w_parked;
  logic w_sym_cap, w_bit_xfer, w_sym_xfer, w_last_bit;
  logic w_burst_done, w_last_frame, w_wd_expire;
  logic [FRAME_W-1:0] w_frames_inc;

  assign w_stream = (r_state == S_STREAM);
  assign w_drain  = (r_state == S_DRAIN);
  assign w_active = w_stream | w_drain;
  assign w_parked = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR);

  // Once a burst has all its symbols, refuse more so a fast modulator can
  // never be counted into the wrong burst.
  assign w_sym_cap  = (r_sym_cnt == SYM_W'(SYMS));
  assign w_bit_xfer = w_stream & i_src_valid & i_phy_ready;
  assign w_sym_xfer = i_mod_valid & o_mod_ready;
  assign w_last_bit = w_bit_xfer & (r_in_cnt == IN_W'(BLOCK_BITS - 1));

  // Completion is taken in DRAIN only; symbols that arrived during STREAM
  // already sit in r_sym_cnt.
  assign w_burst_done = w_drain &
                        (w_sym_cap | (w_sym_xfer & (r_sym_cnt == SYM_W'(SYMS - 1))));
  assign w_frames_inc = r_frames_sent + FRAME_W'(1);
  assign w_last_frame = (r_num_frames != '0) & (w_frames_inc == r_num_frames);
  assign w_wd_expire  = w_active & ~w_bit_xfer & ~w_sym_xfer &
                        (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Bit path is a combinational pass-through gated by state, so the
  // randomizer sees the upstream handshake with no added latency.
  assign o_phy_load    = (r_state == S_LOAD);
  assign o_phy_en      = w_active;
  assign o_phy_data    = w_stream & i_src_data;
  assign o_phy_valid   = w_stream & i_src_valid;
  assign o_src_ready   = w_stream & i_phy_ready;
  assign o_mod_ready   = w_active & ~w_sym_cap;
  assign o_busy        = ~w_parked;
  assign o_frame_done  = w_burst_done;
  assign o_frames_sent = r_frames_sent;
  assign o_timeout_err = r_timeout_err;

  always_ff @(posedge i_clk_50) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_in_cnt      <= '0;
      r_sym_cnt     <= '0;
      r_wd          <= '0;
      r_num_frames  <= '0;
      r_frames_sent <= '0;
      r_stop_req    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state       <= S_LOAD;
            r_num_frames  <= i_num_frames;
            r_frames_sent <= '0;
            r_stop_req    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_in_cnt      <= '0;
            r_sym_cnt     <= '0;
            r_wd          <= '0;
          end
        end
        S_LOAD: begin
          r_state <= S_STREAM;
          r_wd    <= '0;
          if (i_stop) r_stop_req <= 1'b1;
        end
        S_STREAM, S_DRAIN: begin
          if (i_stop) r_stop_req <= 1'b1;
          if (w_bit_xfer) r_in_cnt <= r_in_cnt + IN_W'(1);
          if (w_last_bit) r_state <= S_DRAIN;
          if (w_sym_xfer) r_sym_cnt <= r_sym_cnt + SYM_W'(1);
          if (w_bit_xfer | w_sym_xfer) r_wd <= '0;
          else                         r_wd <= r_wd + WD_W'(1);
          if (w_burst_done) begin
            r_frames_sent <= w_frames_inc;
            r_in_cnt      <= '0;
            r_sym_cnt     <= '0;
            r_state       <= (r_stop_req | i_stop | w_last_frame) ? S_DONE : S_LOAD;
          end else if (w_wd_expire) begin
            // Counters stay frozen so the stall point can be inspected.
            r_state       <= S_ERROR;
            r_timeout_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wimax_burst_sequencer.sv
module tb_wimax_burst_sequencer;
  localparam int BB = 96;
  localparam int TO = 16;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1, i_start = 1'b0, i_stop = 1'b0;
  logic [FW-1:0] i_num_frames = '0;
  logic          i_src_data = 1'b0, i_src_valid = 1'b0, i_phy_ready = 1'b0, i_mod_valid = 1'b0;
  logic          o_src_ready, o_phy_load, o_phy_en, o_phy_data, o_phy_valid;
  logic          o_mod_ready, o_busy, o_frame_done, o_timeout_err;
  logic [FW-1:0] o_frames_sent;

  always #5 clk = ~clk;

  wimax_burst_sequencer #(.BLOCK_BITS(BB), .TIMEOUT_CYCLES(TO), .FRAME_W(FW)) dut (
    .i_clk_50(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_num_frames(i_num_frames), .i_src_data(i_src_data), .i_src_valid(i_src_valid),
    .o_src_ready(o_src_ready), .o_phy_load(o_phy_load), .o_phy_en(o_phy_en),
    .o_phy_data(o_phy_data), .o_phy_valid(o_phy_valid), .i_phy_ready(i_phy_ready),
    .i_mod_valid(i_mod_valid), .o_mod_ready(o_mod_ready), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_frames_sent(o_frames_sent), .o_timeout_err(o_timeout_err)
  );

  int n_cmp = 0, n_err = 0;

  // stimulus knobs and chain model
  int stall_pct = 0, rdy_pct = 100, mod_pct = 100, gate = 0;
  bit mod_en = 1'b1;
  bit src_q[$];
  bit exp_bits[$];
  int done_q[$];
  int cyc = 0, start_cyc = 0;
  int n_load, n_bits, n_syms, n_done, n_stream_syms;
  int bits_in_burst, syms_in_burst, pending;
  int first_load_cyc, first_bit_cyc, last_bit_cyc;

  // Scoreboard: every bit the randomizer accepts must be the next bit queued
  // by the stimulus, in order.
  always @(negedge clk) begin
    if (o_phy_valid && i_phy_ready) begin
      n_cmp++;
      if (exp_bits.size() == 0) begin
        n_err++;
        $display("FAIL phy_data: got bit %b, required no transfer (queue empty)", o_phy_data);
      end else begin
        bit e;
        e = exp_bits.pop_front();
        if (o_phy_data !== e) begin
          n_err++;
          $display("FAIL phy_data: got %b, required %b", o_phy_data, e);
        end
      end
    end
  end

  task automatic clr_stats();
    n_load = 0; n_bits = 0; n_syms = 0; n_done = 0; n_stream_syms = 0;
    bits_in_burst = 0; syms_in_burst = 0; pending = 0;
    first_load_cyc = -1; first_bit_cyc = -1; last_bit_cyc = -1;
    done_q.delete();
  endtask

  task automatic load_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = 1'($urandom_range(1));
      src_q.push_back(b);
      exp_bits.push_back(b);
    end
  endtask

  task automatic drive();
    i_src_valid = (src_q.size() > 0) && (int'($urandom_range(99)) >= stall_pct);
    i_src_data  = (src_q.size() > 0) ? src_q[0] : 1'b0;
    i_phy_ready = int'($urandom_range(99)) < rdy_pct;
    // Modulator emits one symbol per two accepted bits, optionally held back
    // until `gate` bits of the burst have gone in.
    i_mod_valid = mod_en && (pending > 0) && (bits_in_burst >= gate) &&
                  (int'($urandom_range(99)) < mod_pct);
  endtask

  // One clock: sample at negedge, update the chain model, drive after posedge.
  task automatic step();
    bit bx, sx, dummy;
    @(negedge clk);
    cyc++;
    bx = i_src_valid && o_src_ready;
    sx = i_mod_valid && o_mod_ready;
    if (o_phy_load) begin
      n_load++; bits_in_burst = 0; syms_in_burst = 0;
      if (first_load_cyc < 0) first_load_cyc = cyc;
    end
    if (o_phy_valid && i_phy_ready) begin
      n_bits++; last_bit_cyc = cyc;
      if (first_bit_cyc < 0) first_bit_cyc = cyc;
    end
    if (sx) begin
      pending--; n_syms++; syms_in_burst++;
      if (o_phy_en && bits_in_burst < BB) n_stream_syms++;
    end
    if (bx) begin
      dummy = src_q.pop_front();
      bits_in_burst++;
      if (bits_in_burst % 2 == 0) pending++;
    end
    if (o_frame_done) begin
      n_done++; done_q.push_back(syms_in_burst); syms_in_burst = 0;
    end
    @(posedge clk); #1;
    drive();
  endtask

  task automatic do_start(input logic [FW-1:0] nf);
    i_start = 1'b1; i_num_frames = nf;
    start_cyc = cyc + 1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int k;
    k = 0;
    while (o_busy && k < budget) begin step(); k++; end
    timed_out = o_busy;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(); step();
    n_cmp++;
    if ({o_busy, o_phy_en, o_phy_load, o_src_ready, o_phy_valid, o_mod_ready,
         o_frame_done, o_timeout_err} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {o_busy, o_phy_en, o_phy_load, o_src_ready, o_phy_valid, o_mod_ready,
                o_frame_done, o_timeout_err});
    end
    n_cmp++;
    if (o_frames_sent !== 8'd0) begin
      n_err++; $display("FAIL reset_frames_sent: got %0d, required 0", o_frames_sent);
    end
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit to;
    clr_stats();
    stall_pct = 0; rdy_pct = 100; mod_pct = 100; mod_en = 1'b1; gate = BB;
    load_bits(BB); drive();
    do_start(8'd1);
    wait_idle(2000, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL single_timeout: still busy, required idle"); end
    n_cmp++; if (first_load_cyc - start_cyc !== 1) begin n_err++; $display("FAIL single_load_lat: got %0d, required 1", first_load_cyc - start_cyc); end
    n_cmp++; if (first_bit_cyc - start_cyc !== 2) begin n_err++; $display("FAIL single_bit_lat: got %0d, required 2", first_bit_cyc - start_cyc); end
    n_cmp++; if (n_load !== 1) begin n_err++; $display("FAIL single_loads: got %0d, required 1", n_load); end
    n_cmp++; if (n_bits !== BB) begin n_err++; $display("FAIL single_bits: got %0d, required %0d", n_bits, BB); end
    n_cmp++; if (n_syms !== BB/2) begin n_err++; $display("FAIL single_syms: got %0d, required %0d", n_syms, BB/2); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL single_done: got %0d, required 1", n_done); end
    n_cmp++; if (o_frames_sent !== 8'd1) begin n_err++; $display("FAIL single_frames: got %0d, required 1", o_frames_sent); end
    n_cmp++; if (o_timeout_err !== 1'b0) begin n_err++; $display("FAIL single_terr: got %b, required 0", o_timeout_err); end
  endtask

  task automatic test_multi();
    bit to;
    clr_stats();
    stall_pct = 20; rdy_pct = 80; mod_pct = 80; mod_en = 1'b1; gate = 0;
    load_bits(3*BB); drive();
    do_start(8'd3);
    wait_idle(5000, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL multi_timeout: still busy, required idle"); end
    n_cmp++; if (n_load !== 3) begin n_err++; $display("FAIL multi_loads: got %0d, required 3", n_load); end
    n_cmp++; if (n_bits !== 3*BB) begin n_err++; $display("FAIL multi_bits: got %0d, required %0d", n_bits, 3*BB); end
    n_cmp++; if (n_syms !== 3*BB/2) begin n_err++; $display("FAIL multi_syms: got %0d, required %0d", n_syms, 3*BB/2); end
    n_cmp++; if (o_frames_sent !== 8'd3) begin n_err++; $display("FAIL multi_frames: got %0d, required 3", o_frames_sent); end
    n_cmp++; if (o_timeout_err !== 1'b0) begin n_err++; $display("FAIL multi_terr: got %b, required 0", o_timeout_err); end
    n_cmp++; if (done_q.size() !== 3) begin n_err++; $display("FAIL multi_done: got %0d, required 3", done_q.size()); end
    foreach (done_q[i]) begin
      n_cmp++;
      if (done_q[i] !== BB/2) begin n_err++; $display("FAIL multi_syms_at_done[%0d]: got %0d, required %0d", i, done_q[i], BB/2); end
    end
  endtask

  task automatic test_stop();
    bit to;
    int k;
    clr_stats();
    stall_pct = 0; rdy_pct = 100; mod_pct = 100; mod_en = 1'b1; gate = 0;
    load_bits(3*BB); drive();
    do_start(8'd0);
    k = 0;
    while (!(n_load == 2 && bits_in_burst >= 30) && k < 2000) begin step(); k++; end
    n_cmp++; if (k >= 2000) begin n_err++; $display("FAIL stop_reach_burst2: not reached, required burst 2 bit 30"); end
    i_stop = 1'b1; step(); i_stop = 1'b0;
    wait_idle(2000, to);
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL stop_timeout: still busy, required idle"); end
    n_cmp++; if (n_load !== 2) begin n_err++; $display("FAIL stop_loads: got %0d, required 2", n_load); end
    n_cmp++; if (n_done !== 2) begin n_err++; $display("FAIL stop_done: got %0d, required 2", n_done); end
    n_cmp++; if (o_frames_sent !== 8'd2) begin n_err++; $display("FAIL stop_frames: got %0d, required 2", o_frames_sent); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b, required 0", o_busy); end
    src_q.delete(); exp_bits.delete(); drive();
  endtask

  task automatic test_watchdog();
    bit to;
    int k;
    clr_stats();
    stall_pct = 0; rdy_pct = 100; mod_pct = 100; mod_en = 1'b0; gate = 0;
    load_bits(BB); drive();
    do_start(8'd1);
    k = 0;
    while (!o_timeout_err && k < 500) begin step(); k++; end
    n_cmp++; if (o_timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_flag: got %b, required 1", o_timeout_err); end
    n_cmp++; if (n_bits !== BB) begin n_err++; $display("FAIL wd_bits: got %0d, required %0d", n_bits, BB); end
    // TO idle cycles follow the last transfer; ERROR is visible the cycle after.
    n_cmp++; if ((cyc + 1) - last_bit_cyc !== TO + 1) begin n_err++; $display("FAIL wd_latency: got %0d, required %0d", (cyc + 1) - last_bit_cyc, TO + 1); end
    n_cmp++; if ({o_phy_en, o_busy, o_mod_ready} !== 3'b000) begin n_err++; $display("FAIL wd_outputs: got %b, required 000", {o_phy_en, o_busy, o_mod_ready}); end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL wd_done: got %0d, required 0", n_done); end
    clr_stats();
    mod_en = 1'b1; gate = BB;
    load_bits(BB); drive();
    do_start(8'd1);
    n_cmp++; if (o_timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b, required 0", o_timeout_err); end
    wait_idle(2000, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL wd_rerun_timeout: still busy, required idle"); end
    n_cmp++; if (o_frames_sent !== 8'd1) begin n_err++; $display("FAIL wd_rerun_frames: got %0d, required 1", o_frames_sent); end
    n_cmp++; if (o_timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_rerun_terr: got %b, required 0", o_timeout_err); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int k;
    clr_stats();
    stall_pct = 0; rdy_pct = 100; mod_pct = 100; mod_en = 1'b1; gate = BB;
    load_bits(BB); drive();
    do_start(8'd1);
    k = 0;
    while (bits_in_burst < 40 && k < 500) begin step(); k++; end
    i_reset = 1'b1; step(); i_reset = 1'b0;
    // Upstream still offers valid with ready high; gating must hold everything low.
    n_cmp++;
    if ({o_busy, o_phy_en, o_phy_load, o_src_ready, o_phy_valid, o_mod_ready, o_frame_done} !== 7'b0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %b, required 0000000",
               {o_busy, o_phy_en, o_phy_load, o_src_ready, o_phy_valid, o_mod_ready, o_frame_done});
    end
    n_cmp++; if (o_frames_sent !== 8'd0) begin n_err++; $display("FAIL rstmid_frames: got %0d, required 0", o_frames_sent); end
    src_q.delete(); exp_bits.delete(); drive();
    step();
    clr_stats();
    load_bits(BB); drive();
    do_start(8'd1);
    wait_idle(2000, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rstmid_timeout: still busy, required idle"); end
    n_cmp++; if (n_bits !== BB) begin n_err++; $display("FAIL rstmid_bits: got %0d, required %0d", n_bits, BB); end
    n_cmp++; if (n_load !== 1) begin n_err++; $display("FAIL rstmid_loads: got %0d, required 1", n_load); end
    n_cmp++; if (o_frames_sent !== 8'd1) begin n_err++; $display("FAIL rstmid_frames2: got %0d, required 1", o_frames_sent); end
  endtask

  task automatic test_early_sym();
    bit to;
    clr_stats();
    stall_pct = 0; rdy_pct = 100; mod_pct = 100; mod_en = 1'b1; gate = 60;
    load_bits(BB); drive();
    do_start(8'd1);
    wait_idle(2000, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL early_timeout: still busy, required idle"); end
    // Symbols flow one per cycle from bit 61 through bit 96.
    n_cmp++; if (n_stream_syms !== BB - 60) begin n_err++; $display("FAIL early_stream_syms: got %0d, required %0d", n_stream_syms, BB - 60); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL early_done: got %0d, required 1", n_done); end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] !== BB/2) begin
      n_err++; $display("FAIL early_syms_at_done: got %0d entries, required one of %0d", done_q.size(), BB/2);
    end
    n_cmp++; if (o_frames_sent !== 8'd1) begin n_err++; $display("FAIL early_frames: got %0d, required 1", o_frames_sent); end
  endtask

  initial begin
    clr_stats();
    test_reset();
    test_single();
    test_multi();
    test_stop();
    test_watchdog();
    test_reset_mid();
    test_early_sym();
    n_cmp++;
    if (exp_bits.size() != 0) begin n_err++; $display("FAIL leftover_bits: got %0d, required 0", exp_bits.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not end, required finish");
    $fatal(1);
  end

endmodule
